conv_idx_loader: RTL and testbench
==================================

Name: conv_idx_loader

Overview:
- Writer side of the convolution index buffer.
- Accepts a stream of sparse kernel indices, packs two IDX_W indices per buffer word and writes them to the index buffer.
- Then hands the entry count to the convolution AGU, pulses its start and waits for its done.
- Sits between the DDR/stream unpacker and the index buffer/AGU pair; it fills the buffer that the AGU reads through its idx_rd_addr/idx port.

Parameters:
- ADDR_W, 8, index buffer address width; buffer capacity CAP = min(256, 2^ADDR_W) words.
- IDX_W, GLOBAL_PARAM::IDX_W, width of one index; a buffer word is IDX_W*2 bits.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin loading one index set; honoured only in IDLE
- done  out  1  one-cycle pulse after the AGU reports completion
- conf_base_addr  in  ADDR_W  first buffer word address; latched on accepted start
- in_idx  in  IDX_W  stream index
- in_valid  in  1  stream valid
- in_last  in  1  marks final index of the set
- in_ready  out  1  stream ready
- idx_wr_en  out  1  buffer write enable
- idx_wr_addr  out  ADDR_W  buffer write address
- idx_wr_data  out  IDX_W*2  packed word: {second index, first index}, first in low half
- agu_start  out  1  one-cycle start pulse to AGU
- agu_idx_cnt  out  8  number of words written, for AGU conf_idx_cnt
- agu_done  in  1  AGU completion pulse
- overflow  out  1  sticky: set stream exceeded CAP words

Behaviour:
- Reset values: all outputs 0, state IDLE, word count 0, half-valid flag 0.
- rst mid-operation aborts immediately to IDLE. No write or pulse is issued in the reset cycle or the cycle after.
- States: IDLE -> LOAD -> KICK -> WAIT -> IDLE.
- IDLE:
  - in_ready=0.
  - On start: latch conf_base_addr, clear count, half flag and overflow, go to LOAD.
- LOAD:
  - in_ready=1.
  - Beats are accepted on in_valid & in_ready.
  - Accepted beat with half flag 0 and in_last 0: store in_idx in the low-half register and set the half flag. No write.
  - Accepted beat with half flag 1: register a write of {in_idx, held}, then clear the half flag.
  - Accepted beat with half flag 0 and in_last 1: register a write of {PAD, in_idx}, with PAD = all ones (IDX_W bits).
  - The write is presented the cycle after acceptance: idx_wr_en=1 for exactly one cycle, idx_wr_addr = (base + count) mod 2^ADDR_W, count increments with the write.
  - Accepted in_last -> KICK next cycle. The final write appears in that first KICK cycle.
- Overflow:
  - If a write would make count > CAP, suppress it (idx_wr_en stays 0), set overflow and keep count at CAP.
  - Keep accepting until in_last; the remainder of the set is dropped.
- KICK: one cycle after the final write slot, pulse agu_start for 1 cycle, then go to WAIT.
- agu_idx_cnt = count, stable from the agu_start cycle until the next accepted start. A count of 256 (CAP=256) is reported as 0, and overflow is set in that case.
- WAIT:
  - in_ready=0.
  - On agu_done: pulse done the next cycle and return to IDLE.
  - agu_done in any other state is ignored.
- start outside IDLE is ignored.
- Timing: last accepted at cycle T -> final write T+1 -> agu_start T+2 -> agu_done at D -> done at D+1.
- Address arithmetic wraps modulo 2^ADDR_W; base near the top wraps to 0.
- Throughput: one index per cycle sustained, one write per two indices. No backpressure in LOAD unless overflow handling forces it (it does not; in_ready stays 1).

Test Plan:
- Even set: base=0x10, indices 1,2,3,4 (last on 4) -> writes addr 0x10 data {2,1}, addr 0x11 data {4,3}; agu_start 2 cycles after last with agu_idx_cnt=2; agu_done -> done next cycle.
- Odd set: indices 5,6,7 -> writes {6,5}, then {PAD,7} with PAD=all ones; agu_idx_cnt=2.
- Wrap with stalls: ADDR_W=8, base=0xFF, 4 indices with in_valid gapped every other cycle -> writes at 0xFF then 0x00; pairing unaffected by stalls.
- Overflow: ADDR_W=2 (CAP=4), 12 indices -> exactly 4 writes, overflow=1, agu_idx_cnt=4, all 12 beats accepted.
- Protocol robustness: start pulsed in LOAD and WAIT, and agu_done pulsed in LOAD -> no effect. Next start clears overflow.
- Reset mid-LOAD after 3 indices -> outputs 0, state IDLE, no agu_start; a fresh start loads cleanly from count 0.

Source files
------------

// File: rtl/conv_idx_loader.sv
// Writer side of the convolution index buffer: packs pairs of sparse kernel
// indices into buffer words, then kicks the AGU and waits for it to finish.
module conv_idx_loader #(
  parameter int ADDR_W = 8,
  parameter int IDX_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  done,
  input  logic [ADDR_W-1:0]     conf_base_addr,
  input  logic [IDX_W-1:0]      in_idx,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  idx_wr_en,
  output logic [ADDR_W-1:0]     idx_wr_addr,
  output logic [IDX_W*2-1:0]    idx_wr_data,
  output logic                  agu_start,
  output logic [7:0]            agu_idx_cnt,
  input  logic                  agu_done,
  output logic                  overflow
);

  localparam int CAP = (ADDR_W >= 8) ? 256 : (1 << ADDR_W);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [8:0]        count;   // 0..256 words
  logic              half;
  logic [IDX_W-1:0]  held;
  logic              beat;

  assign in_ready    = (state == S_LOAD);
  assign beat        = in_valid & in_ready;
  assign agu_idx_cnt = count[7:0];

  // NOTE: every output of an always_comb gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  if (beat && in_last) state_nxt = S_KICK;
      S_KICK:  state_nxt = S_WAIT;
      S_WAIT:  if (agu_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      base        <= '0;
      count       <= '0;
      half        <= 1'b0;
      held        <= '0;
      overflow    <= 1'b0;
      idx_wr_en   <= 1'b0;
      idx_wr_addr <= '0;
      idx_wr_data <= '0;
      agu_start   <= 1'b0;
      done        <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx_wr_en <= 1'b0;
      agu_start <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            base     <= conf_base_addr;
            count    <= '0;
            half     <= 1'b0;
            overflow <= 1'b0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (!half && !in_last) begin
              held <= in_idx;
              half <= 1'b1;
            end else begin
              half <= 1'b0;
              // Past capacity the word is dropped but pairing keeps running.
              if (count < 9'(CAP)) begin
                idx_wr_en   <= 1'b1;
                idx_wr_addr <= base + ADDR_W'(count);
                idx_wr_data <= half ? {in_idx, held} : {{IDX_W{1'b1}}, in_idx};
                count       <= count + 9'd1;
                // A full 256-word set cannot be expressed in the 8-bit count.
                if (count == 9'd255) overflow <= 1'b1;
              end else begin
                overflow <= 1'b1;
              end
            end
          end
        end
        S_KICK:  agu_start <= 1'b1;
        S_WAIT:  if (agu_done) done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_idx_loader.sv
// Self-checking bench: two loaders (ADDR_W=8 and ADDR_W=2) share one stimulus
// stream; each is compared against a word-level packing model.
module tb_conv_idx_loader;
  localparam int IDX_W = 8;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] data;
    int          cyc;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst, start, in_valid, in_last, agu_done;
  logic [7:0]       conf_base_addr;
  logic [IDX_W-1:0] in_idx;

  logic        a_done, a_in_ready, a_wr_en, a_agu_start, a_ovf;
  logic [7:0]  a_wr_addr, a_cnt;
  logic [15:0] a_wr_data;
  logic        b_done, b_in_ready, b_wr_en, b_agu_start, b_ovf;
  logic [1:0]  b_wr_addr;
  logic [7:0]  b_cnt;
  logic [15:0] b_wr_data;

  conv_idx_loader #(.ADDR_W(8), .IDX_W(IDX_W)) u_a (
    .clk(clk), .rst(rst), .start(start), .done(a_done), .conf_base_addr(conf_base_addr),
    .in_idx(in_idx), .in_valid(in_valid), .in_last(in_last), .in_ready(a_in_ready),
    .idx_wr_en(a_wr_en), .idx_wr_addr(a_wr_addr), .idx_wr_data(a_wr_data),
    .agu_start(a_agu_start), .agu_idx_cnt(a_cnt), .agu_done(agu_done), .overflow(a_ovf));

  conv_idx_loader #(.ADDR_W(2), .IDX_W(IDX_W)) u_b (
    .clk(clk), .rst(rst), .start(start), .done(b_done), .conf_base_addr(conf_base_addr[1:0]),
    .in_idx(in_idx), .in_valid(in_valid), .in_last(in_last), .in_ready(b_in_ready),
    .idx_wr_en(b_wr_en), .idx_wr_addr(b_wr_addr), .idx_wr_data(b_wr_data),
    .agu_start(b_agu_start), .agu_idx_cnt(b_cnt), .agu_done(agu_done), .overflow(b_ovf));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  wr_t a_wr[$], b_wr[$];
  int  a_st[$], b_st[$], a_dn[$], b_dn[$];

  always @(negedge clk) begin
    if (a_wr_en) a_wr.push_back('{a_wr_addr, a_wr_data, cyc});
    if (b_wr_en) b_wr.push_back('{{6'd0, b_wr_addr}, b_wr_data, cyc});
    if (a_agu_start) a_st.push_back(cyc);
    if (b_agu_start) b_st.push_back(cyc);
    if (a_done) a_dn.push_back(cyc);
    if (b_done) b_dn.push_back(cyc);
  end

  task automatic clear_mon();
    a_wr.delete(); b_wr.delete(); a_st.delete(); b_st.delete(); a_dn.delete(); b_dn.delete();
  endtask

  // Reference model: indices pair up into words {odd, even}, a lone tail is
  // padded with all ones, words beyond capacity vanish, addresses wrap.
  int  stim[$];
  wr_t exp_w[2][$];
  int  exp_cnt[2];
  bit  exp_ovf[2];

  function automatic void build_expected(input logic [7:0] base);
    int words, cap, kept, aw;
    logic [7:0] lo, hi;
    words = (stim.size() + 1) / 2;
    for (int d = 0; d < 2; d++) begin
      aw   = d ? 2 : 8;
      cap  = (aw >= 8) ? 256 : (1 << aw);
      kept = (words < cap) ? words : cap;
      exp_w[d].delete();
      for (int i = 0; i < kept; i++) begin
        lo = stim[2*i][7:0];
        hi = (2*i + 1 < stim.size()) ? stim[2*i+1][7:0] : 8'hFF;
        exp_w[d].push_back('{8'((int'(base) + i) % (1 << aw)), {hi, lo}, 0});
      end
      exp_cnt[d] = kept % 256;
      exp_ovf[d] = (words > cap) || (kept == 256);
    end
  endfunction

  // Drives one set (start, beats, agu_done) and checks both loaders against the model.
  task automatic run_set(input logic [7:0] base, input int gap, input bit noise);
    int t_last, d_cyc, g, words;
    wr_t got[$];
    int  st[$], dn[$];
    logic [7:0] cnt;
    logic ovf, rdy;
    build_expected(base);
    words = (stim.size() + 1) / 2;
    clear_mon();
    @(posedge clk); #1 start = 1'b1; conf_base_addr = base;
    @(posedge clk); #1 start = 1'b0;
    if (noise) begin
      start = 1'b1; agu_done = 1'b1;
      @(posedge clk); #1 start = 1'b0; agu_done = 1'b0;
    end
    t_last = 0;
    for (int i = 0; i < stim.size(); i++) begin
      g = (gap == 1) ? ((i > 0) ? 1 : 0) : (gap == 2) ? int'($urandom_range(0, 2)) : 0;
      repeat (g) begin @(posedge clk); #1; end
      in_valid = 1'b1; in_idx = stim[i][7:0]; in_last = (i == stim.size() - 1);
      @(negedge clk);
      checks++;
      if (a_in_ready !== 1'b1 || b_in_ready !== 1'b1) begin
        errors++; $display("FAIL in_ready_load beat %0d: got a=%b b=%b expected 1", i, a_in_ready, b_in_ready);
      end
      t_last = cyc;
      @(posedge clk); #1 in_valid = 1'b0; in_last = 1'b0;
    end
    repeat (3) @(negedge clk);
    if (noise) begin start = 1'b1; @(negedge clk); start = 1'b0; end
    for (int d = 0; d < 2; d++) begin
      got = d ? b_wr : a_wr;
      st  = d ? b_st : a_st;
      cnt = d ? b_cnt : a_cnt;
      ovf = d ? b_ovf : a_ovf;
      rdy = d ? b_in_ready : a_in_ready;
      checks++;
      if (got.size() != exp_w[d].size()) begin
        errors++; $display("FAIL wr_count dut%0d: got %0d expected %0d", d, got.size(), exp_w[d].size());
      end else begin
        for (int i = 0; i < got.size(); i++) begin
          checks++;
          if (got[i].addr !== exp_w[d][i].addr || got[i].data !== exp_w[d][i].data) begin
            errors++; $display("FAIL wr_word dut%0d #%0d: got %h/%h expected %h/%h", d, i,
                               got[i].addr, got[i].data, exp_w[d][i].addr, exp_w[d][i].data);
          end
        end
        if (words > 0 && got.size() == words) begin
          checks++;
          if (got[got.size()-1].cyc != t_last + 1) begin
            errors++; $display("FAIL final_wr_time dut%0d: got %0d expected %0d", d, got[got.size()-1].cyc, t_last + 1);
          end
        end
      end
      checks++;
      if (st.size() != 1 || st[0] != t_last + 2) begin
        errors++; $display("FAIL agu_start dut%0d: got %0d pulses first %0d expected 1 at %0d", d, st.size(),
                           (st.size() > 0) ? st[0] : -1, t_last + 2);
      end
      checks++;
      if (cnt !== 8'(exp_cnt[d]) || ovf !== exp_ovf[d]) begin
        errors++; $display("FAIL cnt_ovf dut%0d: got %0d/%b expected %0d/%b", d, cnt, ovf, exp_cnt[d], exp_ovf[d]);
      end
      checks++;
      if (rdy !== 1'b0) begin
        errors++; $display("FAIL in_ready_wait dut%0d: got %b expected 0", d, rdy);
      end
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    agu_done = 1'b1; d_cyc = cyc;
    @(negedge clk); agu_done = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      dn  = d ? b_dn : a_dn;
      rdy = d ? b_in_ready : a_in_ready;
      checks++;
      if (dn.size() != 1 || dn[0] != d_cyc + 1) begin
        errors++; $display("FAIL done dut%0d: got %0d pulses first %0d expected 1 at %0d", d, dn.size(),
                           (dn.size() > 0) ? dn[0] : -1, d_cyc + 1);
      end
      checks++;
      if (rdy !== 1'b0 || (d ? b_cnt : a_cnt) !== 8'(exp_cnt[d])) begin
        errors++; $display("FAIL idle_after_done dut%0d: got rdy=%b cnt=%0d expected 0/%0d", d, rdy,
                           d ? b_cnt : a_cnt, exp_cnt[d]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; agu_done = 1'b0;
    conf_base_addr = '0; in_idx = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({a_done, a_in_ready, a_wr_en, a_wr_addr, a_wr_data, a_agu_start, a_cnt, a_ovf} !== '0 ||
        {b_done, b_in_ready, b_wr_en, b_wr_addr, b_wr_data, b_agu_start, b_cnt, b_ovf} !== '0) begin
      errors++; $display("FAIL reset_outputs: got a_cnt=%h a_rdy=%b b_rdy=%b expected all zero", a_cnt, a_in_ready, b_in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_even();
    stim = '{1, 2, 3, 4};
    run_set(8'h10, 0, 1'b0);
    checks++;
    if (a_wr.size() < 2 || a_wr[0].addr !== 8'h10 || a_wr[0].data !== 16'h0201 ||
        a_wr[1].addr !== 8'h11 || a_wr[1].data !== 16'h0403) begin
      errors++; $display("FAIL even_words: got %0d writes expected 10:0201 11:0403", a_wr.size());
    end
  endtask

  task automatic test_odd();
    stim = '{5, 6, 7};
    run_set(8'h20, 0, 1'b0);
    checks++;
    if (a_wr.size() < 2 || a_wr[0].data !== 16'h0605 || a_wr[1].data !== 16'hFF07 || a_cnt !== 8'd2) begin
      errors++; $display("FAIL odd_words: got %0d writes cnt %0d expected 0605 FF07 cnt 2", a_wr.size(), a_cnt);
    end
  endtask

  task automatic test_wrap_stall();
    stim = '{};
    for (int i = 0; i < 4; i++) stim.push_back(int'($urandom_range(0, 255)));
    run_set(8'hFF, 1, 1'b0);
    checks++;
    if (a_wr.size() < 2 || a_wr[0].addr !== 8'hFF || a_wr[1].addr !== 8'h00) begin
      errors++; $display("FAIL wrap_addr: got %0d writes expected at FF then 00", a_wr.size());
    end
  endtask

  task automatic test_overflow();
    stim = '{};
    for (int i = 0; i < 12; i++) stim.push_back(int'($urandom_range(0, 255)));
    run_set(8'h01, 0, 1'b0);
    checks++;
    if (b_wr.size() != 4 || b_ovf !== 1'b1 || b_cnt !== 8'd4) begin
      errors++; $display("FAIL cap4_overflow: got %0d writes ovf=%b cnt=%0d expected 4/1/4", b_wr.size(), b_ovf, b_cnt);
    end
  endtask

  task automatic test_protocol();
    stim = '{9, 10};
    run_set(8'h30, 0, 1'b1);
    checks++;
    if (b_ovf !== 1'b0 || a_wr.size() != 1) begin
      errors++; $display("FAIL protocol_noise: got ovf=%b writes=%0d expected 0/1", b_ovf, a_wr.size());
    end
  endtask

  task automatic test_mid_reset();
    @(posedge clk); #1 start = 1'b1; conf_base_addr = 8'h40;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_idx = 8'(i + 1); in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; rst = 1'b1;
    clear_mon();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({a_done, a_in_ready, a_wr_en, a_agu_start, a_cnt, a_ovf} !== '0 ||
        {b_done, b_in_ready, b_wr_en, b_agu_start, b_cnt, b_ovf} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: got a_rdy=%b a_cnt=%0d expected zero", a_in_ready, a_cnt);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (a_wr.size() + b_wr.size() + a_st.size() + b_st.size() != 0) begin
      errors++; $display("FAIL mid_reset_quiet: got %0d writes %0d starts expected 0", a_wr.size(), a_st.size());
    end
    stim = '{11, 12, 13};
    run_set(8'h40, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      stim = '{};
      repeat ($urandom_range(1, 14)) stim.push_back(int'($urandom_range(0, 255)));
      run_set(8'($urandom_range(0, 255)), 2, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_full_cap();
    stim = '{};
    for (int i = 0; i < 512; i++) stim.push_back(int'($urandom_range(0, 255)));
    run_set(8'h80, 0, 1'b0);
    checks++;
    if (a_wr.size() != 256 || a_cnt !== 8'd0 || a_ovf !== 1'b1) begin
      errors++; $display("FAIL full_cap: got %0d writes cnt=%0d ovf=%b expected 256/0/1", a_wr.size(), a_cnt, a_ovf);
    end
  endtask

  initial begin
    test_reset();
    test_even();
    test_odd();
    test_wrap_stall();
    test_overflow();
    test_protocol();
    test_mid_reset();
    test_random();
    test_full_cap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
